// File: rtl/inst_fetch.sv
// Instruction fetch unit for the Divvy processor.
// Owns the program counter, presents it to the combinational instruction ROM,
// and registers the returned instruction for decode. Sequences start/halt,
// honours downstream stalls, and applies branch redirects with a one-cycle flush.
module inst_fetch #(
  parameter logic [15:0] START_ADDR = 16'h0000,
  parameter logic [8:0]  HALT_INST  = 9'h1FF
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [15:0] BranchTarget,
  input  logic [8:0]  InstOut,
  output logic [15:0] InstAddress,
  output logic [8:0]  Inst,
  output logic        InstValid,
  output logic        Done,
  output logic [15:0] FetchCount
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [8:0]  inst_q, inst_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [15:0] count_q, count_d;

  // Saturating increment so the count sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // Next-state and next-output logic for the fetch sequencer.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    done_d  = done_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (Start) begin
          state_d = S_RUN;
          pc_d    = START_ADDR;
          count_d = 16'h0000;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        done_d = 1'b0;
        if (BranchTaken) begin
          // Redirect wins over stall; the in-flight fetch becomes a bubble.
          pc_d    = BranchTarget;
          valid_d = 1'b0;
        end else if (Stall) begin
          pc_d    = pc_q;
          valid_d = valid_q;
        end else if (InstOut == HALT_INST) begin
          // Deliver the halt instruction itself, then freeze the PC.
          inst_d  = InstOut;
          valid_d = 1'b1;
          count_d = sat_inc16(count_q);
          state_d = S_HALTED;
          done_d  = 1'b1;
        end else begin
          inst_d  = InstOut;
          valid_d = 1'b1;
          pc_d    = pc_q + 16'd1;
          count_d = sat_inc16(count_q);
        end
      end
      S_HALTED: begin
        valid_d = 1'b0;
        if (Start) begin
          state_d = S_RUN;
          pc_d    = START_ADDR;
          count_d = 16'h0000;
          done_d  = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = START_ADDR;
        inst_d  = 9'h000;
        valid_d = 1'b0;
        done_d  = 1'b0;
        count_d = 16'h0000;
      end
    endcase
  end

  // State and output registers; asynchronous reset returns to IDLE at any time.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= START_ADDR;
      inst_q  <= 9'h000;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign InstAddress = pc_q;
  assign Inst        = inst_q;
  assign InstValid   = valid_q;
  assign Done        = done_q;
  assign FetchCount  = count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch with a behavioural instruction ROM.
module tb_inst_fetch;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic        Stall;
  logic        BranchTaken;
  logic [15:0] BranchTarget;
  logic [8:0]  InstOut;
  logic [15:0] InstAddress;
  logic [8:0]  Inst;
  logic        InstValid;
  logic        Done;
  logic [15:0] FetchCount;

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];
  logic [8:0] e;

  inst_fetch dut (
    .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .InstOut(InstOut),
    .InstAddress(InstAddress), .Inst(Inst), .InstValid(InstValid),
    .Done(Done), .FetchCount(FetchCount)
  );

  always #5 CLK = ~CLK;

  // ROM: 0..4 -> 001..005, 5 -> halt, elsewhere a non-halt pattern (bit 8 clear).
  function automatic logic [8:0] rom(input logic [15:0] a);
    if (a < 16'd5) return a[8:0] + 9'd1;
    else if (a == 16'd5) return 9'h1FF;
    else return {1'b0, a[7:0] ^ 8'hA5};
  endfunction

  always_comb InstOut = rom(InstAddress);

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_inst(input string name);
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: got %h expected <queue empty>", name, Inst);
    end else begin
      e = exp_q.pop_front();
      if (Inst !== e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", name, Inst, e);
      end
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Start = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 16'h0000;
    #13;
    chk16("rst_addr", InstAddress, 16'h0000);
    chk16("rst_inst", {7'd0, Inst}, 16'h0000);
    chk16("rst_valid", {15'd0, InstValid}, 16'd0);
    chk16("rst_done", {15'd0, Done}, 16'd0);
    chk16("rst_count", FetchCount, 16'h0000);
    Reset_n = 1'b1;
    tick();
    BranchTaken = 1'b1; BranchTarget = 16'h0055; Stall = 1'b1;
    tick();
    BranchTaken = 1'b0; Stall = 1'b0;
    chk16("idle_ignore_addr", InstAddress, 16'h0000);
    chk16("idle_ignore_valid", {15'd0, InstValid}, 16'd0);
  endtask

  task automatic test_sequential();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk16("start_addr", InstAddress, 16'h0000);
    chk16("start_valid", {15'd0, InstValid}, 16'd0);
    for (int i = 1; i <= 5; i++) exp_q.push_back(9'(i));
    exp_q.push_back(9'h1FF);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk16("seq_valid", {15'd0, InstValid}, 16'd1);
      pop_inst("seq_inst");
    end
    chk16("seq_done", {15'd0, Done}, 16'd1);
    chk16("seq_count", FetchCount, 16'd6);
    chk16("seq_addr", InstAddress, 16'd5);
    Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 16'h0033;
    tick();
    Stall = 1'b0; BranchTaken = 1'b0;
    chk16("halt_valid_drop", {15'd0, InstValid}, 16'd0);
    chk16("halt_done_hold", {15'd0, Done}, 16'd1);
    chk16("halt_addr_hold", InstAddress, 16'd5);
  endtask

  task automatic test_restart();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk16("restart_done", {15'd0, Done}, 16'd0);
    chk16("restart_count", FetchCount, 16'd0);
    chk16("restart_addr", InstAddress, 16'h0000);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h002);
    tick();
    chk16("restart_valid", {15'd0, InstValid}, 16'd1);
    pop_inst("restart_inst0");
    tick();
    pop_inst("restart_inst1");
  endtask

  task automatic test_stall();
    chk16("pre_stall_addr", InstAddress, 16'd2);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk16("stall_addr", InstAddress, 16'd2);
      chk16("stall_inst", {7'd0, Inst}, 16'h0002);
      chk16("stall_count", FetchCount, 16'd2);
    end
    Stall = 1'b0;
    exp_q.push_back(9'h003);
    tick();
    pop_inst("resume_inst");
    chk16("resume_addr", InstAddress, 16'd3);
    chk16("resume_count", FetchCount, 16'd3);
  endtask

  task automatic test_branch_stall();
    BranchTaken = 1'b1; BranchTarget = 16'h0010; Stall = 1'b1;
    tick();
    BranchTaken = 1'b0; Stall = 1'b0;
    chk16("br_addr", InstAddress, 16'h0010);
    chk16("br_valid", {15'd0, InstValid}, 16'd0);
    chk16("br_count", FetchCount, 16'd3);
    exp_q.push_back(9'h0B5);
    tick();
    chk16("br_tgt_valid", {15'd0, InstValid}, 16'd1);
    pop_inst("br_tgt_inst");
    chk16("br_next_addr", InstAddress, 16'h0011);
  endtask

  task automatic test_wrap();
    BranchTaken = 1'b1; BranchTarget = 16'hFFFF;
    tick();
    BranchTaken = 1'b0;
    chk16("wrap_pre_addr", InstAddress, 16'hFFFF);
    exp_q.push_back(9'h05A);
    tick();
    pop_inst("wrap_inst");
    chk16("wrap_addr", InstAddress, 16'h0000);
    chk16("wrap_done", {15'd0, Done}, 16'd0);
    chk16("wrap_count", FetchCount, 16'd5);
  endtask

  task automatic test_async_reset();
    bit seen_done;
    BranchTaken = 1'b1; BranchTarget = 16'h0007;
    tick();
    BranchTaken = 1'b0;
    chk16("ar_pre_addr", InstAddress, 16'h0007);
    #2 Reset_n = 1'b0;
    #1;
    chk16("ar_addr", InstAddress, 16'h0000);
    chk16("ar_valid", {15'd0, InstValid}, 16'd0);
    chk16("ar_done", {15'd0, Done}, 16'd0);
    chk16("ar_count", FetchCount, 16'd0);
    #3 Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk16("ar_idle_addr", InstAddress, 16'h0000);
      chk16("ar_idle_valid", {15'd0, InstValid}, 16'd0);
    end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 1; i <= 5; i++) exp_q.push_back(9'(i));
    exp_q.push_back(9'h1FF);
    seen_done = 1'b0;
    for (int i = 0; i < 30 && !seen_done; i++) begin
      tick();
      if (InstValid) pop_inst("ar_refetch_inst");
      if (Done) seen_done = 1'b1;
    end
    chk16("ar_done_reached", {15'd0, seen_done}, 16'd1);
    chk16("ar_queue_drained", 16'(exp_q.size()), 16'd0);
    chk16("ar_final_count", FetchCount, 16'd6);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_restart();
    test_stall();
    test_branch_stall();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
